// File: rtl/sv_field_unpacker_pkg.sv
// Shared types and default geometry for the packed-constant field unpacker.
package sv_unpack_pkg;

   localparam int DEF_FIELD_W = 6;
   localparam int DEF_NFIELDS = 15;
   localparam int DEF_OUT_W   = 8;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_e;

   // Extend one default-width field to the default output width.
   function automatic logic [DEF_OUT_W-1:0] extend_field(
      input logic [DEF_FIELD_W-1:0] field,
      input logic                   is_signed
   );
      logic [DEF_OUT_W-1:0] r;
      for (int i = 0; i < DEF_OUT_W; i++) begin
         if (i < DEF_FIELD_W) r[i] = field[i];
         else                 r[i] = is_signed & field[DEF_FIELD_W-1];
      end
      return r;
   endfunction

endpackage

// File: rtl/sv_field_extend.sv
// Selects field idx_i from a packed word and sign/zero-extends it to OUT_W.
module sv_field_extend #(
   parameter int IN_W    = 128,
   parameter int FIELD_W = 6,
   parameter int NFIELDS = 15,
   parameter int OUT_W   = 8,
   parameter int IDX_W   = 4
) (
   input  logic [IN_W-1:0]    word_i,
   input  logic [NFIELDS-1:0] mask_i,
   input  logic [IDX_W-1:0]   idx_i,
   output logic [OUT_W-1:0]   data_o
);

   // Slots are padded to a power of two so any idx_i value selects something defined.
   localparam int NSLOT = 1 << IDX_W;
   localparam int USED_W = NFIELDS * FIELD_W;

   logic [FIELD_W-1:0] field_arr [NSLOT];
   logic [NSLOT-1:0]   mask_pad;
   logic [FIELD_W-1:0] field;
   logic               sign_bit;

   genvar gi;
   generate
      for (gi = 0; gi < NSLOT; gi++) begin : g_slot
         if (gi < NFIELDS) begin : g_real
            assign field_arr[gi] = word_i[gi*FIELD_W +: FIELD_W];
            assign mask_pad[gi]  = mask_i[gi];
         end else begin : g_pad
            assign field_arr[gi] = '0;
            assign mask_pad[gi]  = 1'b0;
         end
      end

      // Bits above the packed fields are deliberately discarded.
      if (IN_W > USED_W) begin : g_unused
         logic unused_hi;
         assign unused_hi = ^word_i[IN_W-1:USED_W];
      end
   endgenerate

   assign field    = field_arr[idx_i];
   assign sign_bit = mask_pad[idx_i] & field[FIELD_W-1];

   generate
      for (gi = 0; gi < OUT_W; gi++) begin : g_ext
         if (gi < FIELD_W) begin : g_copy
            assign data_o[gi] = field[gi];
         end else begin : g_sign
            assign data_o[gi] = sign_bit;
         end
      end
   endgenerate

endmodule

// File: rtl/sv_field_unpacker.sv
// Accepts one packed word and streams its fields out one per handshake.
module sv_field_unpacker #(
   parameter  int IN_W    = 128,
   parameter  int FIELD_W = sv_unpack_pkg::DEF_FIELD_W,
   parameter  int NFIELDS = sv_unpack_pkg::DEF_NFIELDS,
   parameter  int OUT_W   = sv_unpack_pkg::DEF_OUT_W,
   localparam int IDX_W   = $clog2(NFIELDS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [IN_W-1:0]    in_data,
   input  logic [NFIELDS-1:0] in_signed_mask,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   out_data,
   output logic [IDX_W-1:0]   out_index,
   output logic               out_last
);

   import sv_unpack_pkg::*;

   generate
      if (NFIELDS * FIELD_W > IN_W) begin : g_chk_in_w
         $error("NFIELDS*FIELD_W must not exceed IN_W");
      end
      if (OUT_W < FIELD_W) begin : g_chk_out_w
         $error("OUT_W must be at least FIELD_W");
      end
   endgenerate

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFIELDS - 1);

   state_e             state_q, state_d;
   logic [IN_W-1:0]    word_q, word_d;
   logic [NFIELDS-1:0] mask_q, mask_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [OUT_W-1:0]   ext_data;
   logic               is_last;

   sv_field_extend #(
      .IN_W    (IN_W),
      .FIELD_W (FIELD_W),
      .NFIELDS (NFIELDS),
      .OUT_W   (OUT_W),
      .IDX_W   (IDX_W)
   ) u_extend (
      .word_i (word_q),
      .mask_i (mask_q),
      .idx_i  (idx_q),
      .data_o (ext_data)
   );

   assign is_last = (idx_q == LAST_IDX);

   // State register; reset clears everything, even mid-stream.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         word_q  <= '0;
         mask_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         mask_q  <= mask_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state and handshake outputs; outputs are forced to zero while idle.
   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      mask_d    = mask_q;
      idx_d     = idx_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_index = '0;
      out_last  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               word_d  = in_data;
               mask_d  = in_signed_mask;
               idx_d   = '0;
               state_d = STREAM;
            end
         end
         STREAM: begin
            out_valid = 1'b1;
            out_data  = ext_data;
            out_index = idx_q;
            out_last  = is_last;
            if (out_ready) begin
               if (is_last) begin
                  idx_d   = '0;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sv_field_unpacker.sv
// Directed bench for sv_field_unpacker with hand-computed expectations.
module tb_sv_field_unpacker;

   localparam int IN_W = 128;
   localparam int FW   = 6;
   localparam int NF   = 15;
   localparam int OW   = 8;
   localparam int IW   = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [IN_W-1:0] in_data = '0;
   logic [NF-1:0] in_signed_mask = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [OW-1:0] out_data;
   logic [IW-1:0] out_index;
   logic          out_last;

   int total = 0;
   int bad   = 0;

   logic [FW-1:0]   f [NF];
   logic [IN_W-1:0] word;

   always #5 clk = ~clk;

   sv_field_unpacker dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .in_signed_mask (in_signed_mask),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_index      (out_index),
      .out_last       (out_last)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end else begin
         $display("ok   %s: %0h", tag, act);
      end
   endtask

   // Advance one clock; return 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_fields();
      for (int k = 0; k < NF; k++) f[k] = '0;
   endtask

   function automatic logic [IN_W-1:0] pack_fields();
      logic [IN_W-1:0] w;
      w = '0;
      for (int k = 0; k < NF; k++) w[k*FW +: FW] = f[k];
      return w;
   endfunction

   // Present one word for a single accepted handshake (bounded wait for in_ready).
   task automatic send_word(input logic [IN_W-1:0] d, input logic [NF-1:0] m);
      int n;
      n = 0;
      while (!in_ready && n < 40) begin
         step();
         n++;
      end
      check("send_ready", {31'd0, in_ready}, 32'd1);
      in_data        = d;
      in_signed_mask = m;
      in_valid       = 1'b1;
      step();
      in_valid = 1'b0;
      #1;
   endtask

   // Drain the remaining fields with out_ready held high (bounded).
   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while (out_valid && n < 40) begin
         step();
         n++;
      end
      check("drain_idle", {31'd0, out_valid}, 32'd0);
   endtask

   // Expected field values for the unsigned stream, index order.
   logic [OW-1:0] exp_unsigned [NF] = '{8'h08, 8'h3E, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                        8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E};

   initial begin
      // Reset then idle
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data",  {24'd0, out_data},  32'd0);
      check("rst_out_index", {28'd0, out_index}, 32'd0);
      check("rst_out_last",  {31'd0, out_last},  32'd0);

      // Unsigned stream; inputs wiggle during the stream and must be ignored
      clear_fields();
      f[0] = 6'b001000;
      f[1] = 6'b111110;
      for (int k = 2; k < NF; k++) f[k] = FW'(k);
      word = pack_fields();
      out_ready = 1'b1;
      send_word(word, '0);
      in_valid       = 1'b1;
      in_data        = ~word;
      in_signed_mask = '1;
      for (int k = 0; k < NF; k++) begin
         if (k == NF - 1) in_valid = 1'b0;
         #1;
         check($sformatf("uns_valid[%0d]", k), {31'd0, out_valid}, 32'd1);
         check($sformatf("uns_index[%0d]", k), {28'd0, out_index}, k);
         check($sformatf("uns_data[%0d]", k),  {24'd0, out_data},  {24'd0, exp_unsigned[k]});
         check($sformatf("uns_last[%0d]", k),  {31'd0, out_last},  (k == NF - 1) ? 32'd1 : 32'd0);
         check($sformatf("uns_inrdy[%0d]", k), {31'd0, in_ready},  32'd0);
         step();
      end
      check("uns_end_in_ready",  {31'd0, in_ready},  32'd1);
      check("uns_end_out_valid", {31'd0, out_valid}, 32'd0);
      check("uns_end_index",     {28'd0, out_index}, 32'd0);

      // Signed extension, per-field mask
      clear_fields();
      f[0] = 6'b100000;
      f[1] = 6'b111110;
      f[2] = 6'b011111;
      f[3] = 6'b100000;
      send_word(pack_fields(), 15'b000000000001110);
      check("sgn_idx0", {24'd0, out_data}, 32'h20);
      step();
      check("sgn_idx1", {24'd0, out_data}, 32'hFE);
      step();
      check("sgn_idx2", {24'd0, out_data}, 32'h1F);
      step();
      check("sgn_idx3", {24'd0, out_data}, 32'hE0);
      drain();

      // Backpressure at index 4
      clear_fields();
      f[4] = 6'b101010;
      f[5] = 6'b010101;
      out_ready = 1'b1;
      send_word(pack_fields(), 15'b000000000010000);
      for (int k = 0; k < 4; k++) step();
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("bp_data[%0d]", c),  {24'd0, out_data},  32'hEA);
         check($sformatf("bp_index[%0d]", c), {28'd0, out_index}, 32'd4);
         check($sformatf("bp_valid[%0d]", c), {31'd0, out_valid}, 32'd1);
         step();
      end
      check("bp_still4", {28'd0, out_index}, 32'd4);
      out_ready = 1'b1;
      step();
      check("bp_index5", {28'd0, out_index}, 32'd5);
      check("bp_data5",  {24'd0, out_data},  32'h15);
      drain();

      // Ignored upper bits, all fields zero, all signed
      word = '0;
      word[127:90] = '1;
      send_word(word, '1);
      for (int k = 0; k < NF; k++) begin
         check($sformatf("ign_data[%0d]", k), {24'd0, out_data}, 32'h00);
         step();
      end
      check("ign_end_in_ready", {31'd0, in_ready}, 32'd1);

      // Reset mid-stream at index 7
      clear_fields();
      for (int k = 0; k < NF; k++) f[k] = 6'h3F;
      send_word(pack_fields(), '1);
      for (int k = 0; k < 7; k++) step();
      check("mid_at7", {28'd0, out_index}, 32'd7);
      check("mid_data7", {24'd0, out_data}, 32'hFF);
      rst = 1'b1;
      step();
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_ready", {31'd0, in_ready},  32'd1);
      check("mid_rst_index", {28'd0, out_index}, 32'd0);
      check("mid_rst_data",  {24'd0, out_data},  32'd0);
      rst = 1'b0;
      clear_fields();
      f[0] = 6'h05;
      send_word(pack_fields(), '0);
      check("mid_new_index", {28'd0, out_index}, 32'd0);
      check("mid_new_data",  {24'd0, out_data},  32'h05);
      step();
      check("mid_new_index1", {28'd0, out_index}, 32'd1);
      check("mid_new_data1",  {24'd0, out_data},  32'h00);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule
